// File: rtl/pkt_bank_arbiter_pkg.sv
// Shared types and default sizing for the packet/feature SRAM bank arbiter.
package pkt_bank_arbiter_pkg;

    localparam int ARB_NUM_REQ       = 4;
    localparam int ARB_GRANT_TIMEOUT = 15;

    typedef enum logic [1:0] {
        ARB_IDLE,
        ARB_WAIT,
        ARB_STREAM,
        ARB_RELEASE
    } arb_state_e;

endpackage

// File: rtl/pkt_bank_arbiter_rr_pick.sv
// Rotate-priority encoder: first set req bit at or after rr_ptr, modulo NUM_REQ.
// Purely combinational; no backpressure.
module pkt_bank_arbiter_rr_pick #(
    parameter  int NUM_REQ = 4,
    localparam int IW      = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IW-1:0]      rr_ptr,
    output logic               pick_valid,
    output logic [IW-1:0]      pick_idx,
    output logic [NUM_REQ-1:0] pick_onehot
);

    int            sum;
    logic [IW-1:0] idx_k;

    // Scan from the far end so the candidate nearest rr_ptr is written last and wins.
    always_comb begin
        pick_valid  = 1'b0;
        pick_idx    = '0;
        pick_onehot = '0;
        sum         = 0;
        idx_k       = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            sum = int'(rr_ptr) + k;
            if (sum >= NUM_REQ) sum = sum - NUM_REQ;
            idx_k = IW'(sum);
            if (req[idx_k]) begin
                pick_valid = 1'b1;
                pick_idx   = idx_k;
            end
        end
        if (pick_valid) pick_onehot[pick_idx] = 1'b1;
    end

endmodule

// File: rtl/pkt_bank_arbiter.sv
// Round-robin owner arbitration of the shared SRAM bank, held for a whole stream.
// Grant 1 cycle after req in IDLE; 2 zero-grant cycles between owners; bank_busy stalls IDLE only.
module pkt_bank_arbiter
    import pkt_bank_arbiter_pkg::*;
#(
    parameter  int NUM_REQ       = ARB_NUM_REQ,
    parameter  int GRANT_TIMEOUT = ARB_GRANT_TIMEOUT,
    localparam int IW            = $clog2(NUM_REQ),
    localparam int WW            = $clog2(GRANT_TIMEOUT + 1)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NUM_REQ-1:0] req,
    input  logic [NUM_REQ-1:0] stream_begin,
    input  logic               stream_end,
    input  logic               bank_busy,
    output logic [NUM_REQ-1:0] grant,
    output logic [IW-1:0]      owner,
    output logic               arb_busy,
    output logic               timeout_err
);

    arb_state_e         state, state_nxt;
    logic [IW-1:0]      rr_ptr, rr_ptr_nxt, owner_nxt;
    logic [NUM_REQ-1:0] grant_nxt;
    logic [WW-1:0]      wd_cnt, wd_cnt_nxt;
    logic               timeout_nxt;

    logic               pick_valid;
    logic [IW-1:0]      pick_idx;
    logic [NUM_REQ-1:0] pick_onehot;
    logic               owner_start, owner_drop, wd_expired, can_grant;

    pkt_bank_arbiter_rr_pick #(.NUM_REQ(NUM_REQ)) rr_pick (
        .req         (req),
        .rr_ptr      (rr_ptr),
        .pick_valid  (pick_valid),
        .pick_idx    (pick_idx),
        .pick_onehot (pick_onehot)
    );

    assign owner_start = stream_begin[owner];
    assign owner_drop  = ~req[owner];
    assign wd_expired  = (wd_cnt == WW'(GRANT_TIMEOUT));
    assign can_grant   = pick_valid & ~bank_busy;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= ARB_IDLE;
            rr_ptr      <= '0;
            owner       <= '0;
            grant       <= '0;
            wd_cnt      <= '0;
            timeout_err <= 1'b0;
            arb_busy    <= 1'b0;
        end else begin
            state       <= state_nxt;
            rr_ptr      <= rr_ptr_nxt;
            owner       <= owner_nxt;
            grant       <= grant_nxt;
            wd_cnt      <= wd_cnt_nxt;
            timeout_err <= timeout_nxt;
            arb_busy    <= (state_nxt != ARB_IDLE);
        end
    end

    // A begin and end in the same WAIT cycle is a zero-length stream, not a timeout.
    always_comb begin
        state_nxt = state;
        case (state)
            ARB_IDLE:    if (can_grant) state_nxt = ARB_WAIT;
            ARB_WAIT: begin
                if (owner_start)                   state_nxt = stream_end ? ARB_RELEASE : ARB_STREAM;
                else if (owner_drop || wd_expired) state_nxt = ARB_RELEASE;
            end
            ARB_STREAM:  if (stream_end) state_nxt = ARB_RELEASE;
            ARB_RELEASE: state_nxt = ARB_IDLE;
            default:     state_nxt = ARB_IDLE;
        endcase
    end

    always_comb begin
        grant_nxt   = grant;
        owner_nxt   = owner;
        rr_ptr_nxt  = rr_ptr;
        wd_cnt_nxt  = wd_cnt;
        timeout_nxt = 1'b0;
        case (state)
            ARB_IDLE: begin
                grant_nxt = '0;
                if (can_grant) begin
                    grant_nxt  = pick_onehot;
                    owner_nxt  = pick_idx;
                    wd_cnt_nxt = '0;
                end
            end
            ARB_WAIT: begin
                if (!owner_start && !owner_drop) begin
                    if (wd_expired) timeout_nxt = 1'b1;
                    else            wd_cnt_nxt  = wd_cnt + 1'b1;
                end
            end
            ARB_RELEASE: rr_ptr_nxt = (owner == IW'(NUM_REQ - 1)) ? '0 : owner + 1'b1;
            default: ;
        endcase
        if (state_nxt == ARB_RELEASE) grant_nxt = '0;
    end

endmodule

// File: tb/tb_pkt_bank_arbiter.sv
// Directed and randomized checks of pkt_bank_arbiter against a cycle-level ownership model.
module tb_pkt_bank_arbiter;

    localparam int N  = 4;
    localparam int TO = 15;
    localparam int IW = 2;
    localparam int PH_IDLE = 0, PH_HELD = 1, PH_STREAM = 2, PH_COOL = 3;

    logic          clk = 1'b0;
    logic          reset;
    logic [N-1:0]  req, stream_begin;
    logic          stream_end, bank_busy;
    logic [N-1:0]  grant;
    logic [IW-1:0] owner;
    logic          arb_busy, timeout_err;

    int errors = 0;
    int checks = 0;

    // Model: who holds the bank, in which phase, and how long an unused grant has aged.
    int           m_phase, m_ptr, m_owner, m_age;
    logic [N-1:0] m_grant;
    logic         m_to;

    pkt_bank_arbiter #(.NUM_REQ(N), .GRANT_TIMEOUT(TO)) dut (
        .clk          (clk),
        .reset        (reset),
        .req          (req),
        .stream_begin (stream_begin),
        .stream_end   (stream_end),
        .bank_busy    (bank_busy),
        .grant        (grant),
        .owner        (owner),
        .arb_busy     (arb_busy),
        .timeout_err  (timeout_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int first_from(input logic [N-1:0] r, input int ptr);
        for (int k = 0; k < N; k++)
            if (r[(ptr + k) % N]) return (ptr + k) % N;
        return -1;
    endfunction

    task automatic model_reset();
        m_phase = PH_IDLE; m_ptr = 0; m_owner = 0; m_age = 0; m_grant = '0; m_to = 1'b0;
    endtask

    task automatic model_step();
        int w;
        m_to = 1'b0;
        case (m_phase)
            PH_IDLE: begin
                m_grant = '0;
                w = first_from(req, m_ptr);
                if (w >= 0 && !bank_busy) begin
                    m_owner = w; m_grant = N'(1) << w; m_age = 0; m_phase = PH_HELD;
                end
            end
            PH_HELD: begin
                if (stream_begin[m_owner])  m_phase = stream_end ? PH_COOL : PH_STREAM;
                else if (!req[m_owner])     m_phase = PH_COOL;
                else if (m_age == TO)       begin m_phase = PH_COOL; m_to = 1'b1; end
                else                        m_age++;
                if (m_phase == PH_COOL) m_grant = '0;
            end
            PH_STREAM: if (stream_end) begin m_phase = PH_COOL; m_grant = '0; end
            default: begin
                m_ptr = (m_owner + 1) % N; m_phase = PH_IDLE;
            end
        endcase
    endtask

    task automatic step(input string tag);
        @(posedge clk);
        model_step();
        #1;
        check({tag, ".grant"},    32'(grant),       32'(m_grant));
        check({tag, ".owner"},    32'(owner),       32'(m_owner));
        check({tag, ".arb_busy"}, 32'(arb_busy),    32'(m_phase != PH_IDLE));
        check({tag, ".timeout"},  32'(timeout_err), 32'(m_to));
    endtask

    initial begin
        int zeros, guard;
        reset = 1'b1; req = '0; stream_begin = '0; stream_end = 1'b0; bank_busy = 1'b0;
        model_reset();
        #12;
        check("rst.grant", 32'(grant), 0);
        check("rst.owner", 32'(owner), 0);
        check("rst.busy",  32'(arb_busy), 0);
        check("rst.to",    32'(timeout_err), 0);
        check("rst.rr_ptr", 32'(dut.rr_ptr), 0);
        @(negedge clk) reset = 1'b0;

        // Single requester, 5-cycle stream.
        req = 4'b0100;
        step("single");
        check("single.grant_c", 32'(grant), 32'h4);
        check("single.owner_c", 32'(owner), 2);
        stream_begin = 4'b0100; step("single_sb"); stream_begin = '0;
        for (int i = 0; i < 4; i++) step("single_str");
        stream_end = 1'b1; step("single_se"); stream_end = 1'b0;
        check("single.drop", 32'(grant), 0);
        req = '0; step("single_rel");
        check("single.rr_ptr", 32'(dut.rr_ptr), 3);

        // Fairness from a fresh reset with everyone requesting.
        @(negedge clk) reset = 1'b1;
        #1 model_reset();
        @(negedge clk) reset = 1'b0;
        req = 4'b1111; zeros = 0;
        for (int i = 0; i < 5; i++) begin
            guard = 0;
            while (grant == '0 && guard < 10) begin
                step("fair_wait");
                if (grant == '0) zeros++;
                guard++;
            end
            check("fair.owner", 32'(owner), 32'(i % N));
            check("fair.grant", 32'(grant), 32'(1 << (i % N)));
            if (i > 0) check("fair.gap", 32'(zeros), 2);
            stream_begin = N'(1 << (i % N)); step("fair_sb"); stream_begin = '0;
            step("fair_str"); step("fair_str");
            stream_end = 1'b1; step("fair_se"); stream_end = 1'b0;
            zeros = (grant == '0) ? 1 : 0;
        end
        req = '0; step("fair_end"); step("fair_end");

        // Bank busy holds off the grant.
        req = 4'b0001; bank_busy = 1'b1;
        for (int i = 0; i < 6; i++) begin
            step("busy");
            check("busy.nogrant", 32'(grant), 0);
        end
        bank_busy = 1'b0; step("busy_free");
        check("busy.grant", 32'(grant), 32'h1);
        req = '0; step("busy_drop"); step("busy_idle");

        // Watchdog on requester 1, then rotation to requester 2.
        req = 4'b0110; step("wd_grant");
        check("wd.grant1", 32'(grant), 32'h2);
        for (int k = 1; k <= TO; k++) begin
            step("wd_wait");
            check("wd.quiet", 32'(timeout_err), 0);
        end
        step("wd_fire");
        check("wd.pulse", 32'(timeout_err), 1);
        check("wd.revoke", 32'(grant), 0);
        step("wd_rel"); step("wd_next");
        check("wd.next_owner", 32'(grant), 32'h4);
        req = '0; step("wd_drop"); step("wd_idle");

        // Zero-length stream: begin and end together in WAIT.
        req = 4'b1000; step("zl_grant");
        stream_begin = 4'b1000; stream_end = 1'b1; step("zl_both");
        stream_begin = '0; stream_end = 1'b0;
        check("zl.grant", 32'(grant), 0);
        check("zl.to", 32'(timeout_err), 0);
        req = '0; step("zl_idle");
        check("zl.idle", 32'(arb_busy), 0);

        // Non-owner begin ignored; req drop during stream ignored.
        req = 4'b0001; step("no_grant");
        stream_begin = 4'b0010; step("no_foreign"); stream_begin = '0;
        check("no.foreign_held", 32'(grant), 32'h1);
        stream_begin = 4'b0001; step("no_sb"); stream_begin = '0; req = '0;
        for (int i = 0; i < 3; i++) begin
            step("no_hold");
            check("no.hold", 32'(grant), 32'h1);
        end
        stream_end = 1'b1; step("no_se"); stream_end = 1'b0;
        check("no.end", 32'(grant), 0);
        step("no_idle");

        // Asynchronous reset in the middle of a stream.
        req = 4'b0100; step("ar_grant");
        stream_begin = 4'b0100; step("ar_sb"); stream_begin = '0;
        #2 reset = 1'b1;
        #1;
        check("ar.grant", 32'(grant), 0);
        check("ar.rr_ptr", 32'(dut.rr_ptr), 0);
        check("ar.busy", 32'(arb_busy), 0);
        model_reset();
        @(negedge clk) reset = 1'b0;
        req = 4'b1000; step("ar_after");
        check("ar.regrant", 32'(grant), 32'h8);
        req = '0; step("ar_drop"); step("ar_idle");

        // Randomized traffic against the model.
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(3) == 0) req = N'($urandom);
            bank_busy    = ($urandom_range(3) == 0);
            stream_end   = ($urandom_range(4) == 0);
            stream_begin = '0;
            if ($urandom_range(2) == 0) stream_begin = N'(1 << $urandom_range(N - 1));
            step("rand");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
